// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter: grants a single-port SRAM to the AXI read or write channel.
// Bursts are locked, ties go round-robin and a bounded hold prevents starvation.
module axi_sram_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_size,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_size,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        wr_strb,
  output logic              wr_gnt,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] HM = CW'(HOLD_MAX);
  typedef enum logic [1:0] {IDLE, RD, WR, GAP} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d, cnt_inc;
  logic rd_gnt_q, wr_gnt_q, rd_pend_q, rd_rvalid_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic rd_acc, wr_acc, hold_hit, pick_wr;
  function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
    return size == 3'd0 ? 4'b0001 << a : size == 3'd1 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
  // prio_q high means the write side wins the next tie
  always_comb begin
    rd_acc = rd_gnt_q & rd_req;
    wr_acc = wr_gnt_q & wr_req;
    cnt_inc = (hold_cnt_q == HM || !(rd_acc | wr_acc)) ? hold_cnt_q : hold_cnt_q + 1'b1;
    hold_hit = (HOLD_MAX != 0) && (cnt_inc == HM);
    pick_wr = wr_req & (~rd_req | prio_q);
    state_d = state_q;
    prio_d = prio_q;
    hold_cnt_d = '0;
    rd_data_d = rd_pend_q ? sram_rdata : rd_data_q;
    case (state_q)
      RD: begin
        hold_cnt_d = cnt_inc;
        if (!rd_req || (hold_hit && wr_req)) begin
          state_d = GAP;
          prio_d = 1'b1;
        end
      end
      WR: begin
        hold_cnt_d = cnt_inc;
        if (!wr_req || (hold_hit && rd_req)) begin
          state_d = GAP;
          prio_d = 1'b0;
        end
      end
      default: state_d = pick_wr ? WR : rd_req ? RD : IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      hold_cnt_q <= '0;
      rd_gnt_q <= 1'b0;
      wr_gnt_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_rvalid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      hold_cnt_q <= hold_cnt_d;
      rd_gnt_q <= state_d == RD;
      wr_gnt_q <= state_d == WR;
      rd_pend_q <= rd_acc;
      rd_rvalid_q <= rd_pend_q;
      rd_data_q <= rd_data_d;
    end
  end
  assign rd_gnt = rd_gnt_q;
  assign wr_gnt = wr_gnt_q;
  assign rd_rvalid = rd_rvalid_q;
  assign rd_data = rd_data_q;
  assign sram_cs = rd_acc | wr_acc;
  assign sram_we = wr_acc;
  assign sram_addr = rd_gnt_q ? rd_addr : wr_gnt_q ? wr_addr : '0;
  assign sram_be = rd_acc ? lanes(rd_size, rd_addr[1:0]) :
                   wr_acc ? lanes(wr_size, wr_addr[1:0]) & wr_strb : 4'b0000;
  assign sram_wdata = wr_gnt_q ? wr_data : '0;
endmodule

// File: tb/tb_axi_sram_arbiter.sv
// tb_axi_sram_arbiter: directed beats through per-channel masters, SRAM model and
// a scoreboard monitor comparing SRAM commands and read returns against queues.
module tb_axi_sram_arbiter;
  logic ACLK = 0, ARESETn = 0;
  logic rd_req = 0, wr_req = 0, rd_gnt, wr_gnt, rd_rvalid;
  logic [15:0] rd_addr = 0, wr_addr = 0, sram_addr;
  logic [2:0] rd_size = 0, wr_size = 0;
  logic [31:0] rd_data, wr_data = 0, sram_wdata, sram_rdata = 0;
  logic [3:0] wr_strb = 0, sram_be;
  logic sram_cs, sram_we;
  int vectors = 0, miscompares = 0, cyc = 0, start = 0;
  bit sb_en = 1;
  logic [19:0] rd_cmd_q[$];
  logic [31:0] rd_dat_q[$];
  logic [51:0] wr_cmd_q[$];
  int rd_cyc[$], wr_cyc[$], rv_cyc[$];
  logic [31:0] mem [0:16383];

  axi_sram_arbiter #(.HOLD_MAX(4), .ADDR_W(16), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_rvalid(rd_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_gnt(wr_gnt),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  always @(posedge ACLK) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr[15:2]][8*b +: 8] = sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr[15:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETn && sb_en) begin
      if (sram_cs && sram_we) begin
        if (wr_cmd_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_cmd", {sram_addr, sram_be, sram_wdata}, wr_cmd_q.pop_front());
      end
      if (sram_cs && !sram_we) begin
        if (rd_cmd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_cmd", {sram_addr, sram_be}, rd_cmd_q.pop_front());
      end
      if (rd_rvalid) begin
        rv_cyc.push_back(cyc);
        if (rd_dat_q.size() == 0) chk("rvalid_unexpected", 1, 0);
        else chk("rd_data", rd_data, rd_dat_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic clr();
    rd_cyc.delete();
    wr_cyc.delete();
    rv_cyc.delete();
  endtask

  task automatic rd_master(input logic [15:0] base, input int n, input logic [2:0] size,
                           input logic [31:0] exp, input logic [3:0] be);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      rd_req = 1;
      rd_addr = base + 16'(4 * i);
      rd_size = size;
      rd_cmd_q.push_back({rd_addr, be});
      rd_dat_q.push_back(exp + 32'(i));
      do begin @(negedge ACLK); t++; end while (!rd_gnt && t < 200);
      if (!rd_gnt) begin chk("rd_grant_timeout", 0, 1); break; end
      rd_cyc.push_back(cyc);
      @(posedge ACLK); #1;
    end
    rd_req = 0;
  endtask

  task automatic wr_master(input logic [15:0] base, input int n, input logic [2:0] size,
                           input logic [31:0] data, input logic [3:0] strb, input logic [3:0] be);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      wr_req = 1;
      wr_addr = base + 16'(4 * i);
      wr_size = size;
      wr_data = data + 32'(i);
      wr_strb = strb;
      wr_cmd_q.push_back({wr_addr, be, wr_data});
      do begin @(negedge ACLK); t++; end while (!wr_gnt && t < 200);
      if (!wr_gnt) begin chk("wr_grant_timeout", 0, 1); break; end
      wr_cyc.push_back(cyc);
      @(posedge ACLK); #1;
    end
    wr_req = 0;
  endtask

  initial begin
    int nrv;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h1000_0000 + 32'(i);
    #12;
    chk("reset_ctl", {rd_gnt, wr_gnt, rd_rvalid, sram_cs, sram_we, sram_addr, sram_be}, 0);
    chk("reset_data", {rd_data, sram_wdata}, 0);
    @(posedge ACLK); #1;
    ARESETn = 1;
    idle(2);
    // single 4-beat read burst
    clr();
    start = cyc;
    rd_master(16'h0010, 4, 3'd2, 32'h1000_0004, 4'hF);
    @(negedge ACLK) chk("rd_gnt_hold", rd_gnt, 1);
    @(negedge ACLK) chk("rd_gap", rd_gnt, 0);
    idle(3);
    chk("rd_first_latency", rd_cyc[0] - start, 1);
    chk("rd_back_to_back", rd_cyc[3] - rd_cyc[0], 3);
    chk("rvalid_count", rv_cyc.size(), 4);
    chk("rvalid_lat_first", rv_cyc[0] - rd_cyc[0], 2);
    chk("rvalid_lat_last", rv_cyc[3] - rd_cyc[3], 2);
    // byte lanes and read-back of the merged word
    wr_master(16'h0003, 1, 3'd0, 32'hAB00_0000, 4'hF, 4'b1000);
    idle(2);
    wr_master(16'h0002, 1, 3'd1, 32'h00CC_0000, 4'b0111, 4'b0100);
    idle(2);
    rd_master(16'h0001, 1, 3'd1, 32'hABCC_0000, 4'b0011);
    idle(4);
    // reset during the second beat of a read
    sb_en = 0;
    rd_req = 1; rd_addr = 16'h0040; rd_size = 3'd2;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("mid_rst_gnt_before", rd_gnt, 1);
    @(posedge ACLK); #3;
    ARESETn = 0;
    #1;
    chk("mid_rst_ctl", {rd_gnt, wr_gnt, rd_rvalid, sram_cs, sram_we, sram_addr, sram_be}, 0);
    chk("mid_rst_data", {rd_data, sram_wdata}, 0);
    rd_req = 0;
    idle(2);
    ARESETn = 1;
    nrv = 0;
    repeat (6) begin @(negedge ACLK); nrv += int'(rd_rvalid); end
    chk("mid_rst_no_rvalid", nrv, 0);
    chk("mid_rst_idle", {rd_gnt, wr_gnt}, 0);
    sb_en = 1;
    idle(1);
    // first tie after reset: read wins
    clr();
    start = cyc;
    fork
      rd_master(16'h0300, 2, 3'd2, 32'h1000_00C0, 4'hF);
      wr_master(16'h0400, 2, 3'd2, 32'h7000_0000, 4'hF, 4'hF);
    join
    chk("tie_rd_first", rd_cyc[0] - start, 1);
    chk("tie_wr_after_gap", wr_cyc[0] - rd_cyc[1], 3);
    idle(3);
    // read served last, so the next tie goes to write
    rd_master(16'h0310, 1, 3'd2, 32'h1000_00C4, 4'hF);
    idle(3);
    clr();
    start = cyc;
    fork
      rd_master(16'h0320, 1, 3'd2, 32'h1000_00C8, 4'hF);
      wr_master(16'h0500, 1, 3'd2, 32'h7100_0000, 4'hF, 4'hF);
    join
    chk("tie2_wr_first", wr_cyc[0] - start, 1);
    chk("tie2_rd_after_gap", rd_cyc[0] - wr_cyc[0], 3);
    idle(3);
    // preemption of a long write burst by a read
    clr();
    fork
      wr_master(16'h0100, 20, 3'd2, 32'h5000_0000, 4'hF, 4'hF);
      begin idle(2); rd_master(16'h0200, 3, 3'd2, 32'h1000_0080, 4'hF); end
    join
    chk("pre_wr_run", wr_cyc[3] - wr_cyc[0], 3);
    chk("pre_rd_grant", rd_cyc[0] - wr_cyc[3], 2);
    chk("pre_wr_resume", wr_cyc[4] - rd_cyc[2], 3);
    chk("pre_wr_tail", wr_cyc[19] - wr_cyc[4], 15);
    idle(4);
    chk("drain_rd_cmd", rd_cmd_q.size(), 0);
    chk("drain_rd_data", rd_dat_q.size(), 0);
    chk("drain_wr_cmd", wr_cmd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
